// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: arbiter FSM states, memory owner, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests with a data-burst fairness cap.
// Latency: purely combinational.
// Backpressure: none; the caller only consults the pick while idle.
module mem_arb_pick
  import pipeline_pkg::*;
#(
  parameter int MAX_D_BURST = 4,
  parameter int CNT_W       = 3
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             pick_vld,
  output owner_t           pick_own
);

  logic burst_full;

  assign burst_full = (burst_cnt == CNT_W'(MAX_D_BURST));

  // Data wins by default; fetch wins when alone or once the data burst cap is hit.
  always_comb begin
    pick_vld = if_req | d_req;
    pick_own = OWN_IF;
    if (d_req && !(if_req && burst_full)) begin
      pick_own = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Latency: read done LATENCY+2 cycles after the sampling cycle, store done 2 cycles after.
// Backpressure: requesters stall (combinational) until their done pulse; one access in flight.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LATENCY     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  arb_state_t       state;
  owner_t           owner;
  logic [CNT_W-1:0] burst_cnt;
  logic [LAT_W-1:0] wait_cnt;
  logic             pick_vld;
  owner_t           pick_own;

  mem_arb_pick #(
    .MAX_D_BURST (MAX_D_BURST),
    .CNT_W       (CNT_W)
  ) u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .burst_cnt (burst_cnt),
    .pick_vld  (pick_vld),
    .pick_own  (pick_own)
  );

  // Stall until the done pulse so the pipeline advances at the edge ending DONE.
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  // Access sequencer: strobes default low each cycle and are raised only in their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      burst_cnt <= '0;
      wait_cnt  <= '0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick_own;
            m_en  <= 1'b1;
            state <= ISSUE;
            if (pick_own == OWN_IF) begin
              m_addr    <= if_addr;
              m_wdata   <= '0;
              m_we      <= 1'b0;
              if_gnt    <= 1'b1;
              burst_cnt <= '0;
            end else begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_we    <= d_we;
              d_gnt   <= 1'b1;
              // Only data grants taken while fetch waits count towards the cap.
              if (!if_req) begin
                burst_cnt <= '0;
              end else if (burst_cnt != CNT_W'(MAX_D_BURST)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
              end
            end
          end
        end
        ISSUE: begin
          if (m_we) begin
            // Stores complete without waiting; only the data side can store.
            d_done  <= 1'b1;
            d_rdata <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= LAT_W'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (owner == OWN_IF) begin
              if_rdata <= m_rdata;
              if_done  <= 1'b1;
            end else begin
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural fixed-latency memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: LATENCY=2
  logic        if_req, if_gnt, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we;
  logic [15:0] m_addr, m_wdata, m_rdata;

  // DUT B: LATENCY=1
  logic        b_if_req, b_if_gnt, b_if_done, b_if_stall;
  logic [15:0] b_if_addr, b_if_rdata;
  logic        b_d_req, b_d_we, b_d_gnt, b_d_done, b_d_stall;
  logic [15:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_m_en, b_m_we;
  logic [15:0] b_m_addr, b_m_wdata, b_m_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .LATENCY(2), .MAX_D_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .LATENCY(1), .MAX_D_BURST(4)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done),
    .if_rdata(b_if_rdata), .if_stall(b_if_stall),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
    .d_done(b_d_done), .d_rdata(b_d_rdata), .d_stall(b_d_stall),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
  );

  // Memory models: write at the edge ending ISSUE, read data delayed LATENCY edges.
  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:4095];
  logic [15:0] p_a0, p_a1, p_b0;

  always @(posedge clk) begin
    if (reset) begin
      mem_a[12'h010] <= 16'hA5C3;
      mem_b[12'h003] <= 16'h1111;
      mem_b[12'h004] <= 16'h2222;
    end else begin
      if (m_en && m_we) mem_a[m_addr[11:0]] <= m_wdata;
      if (b_m_en && b_m_we) mem_b[b_m_addr[11:0]] <= b_m_wdata;
    end
    p_a0 <= (m_en && !m_we) ? mem_a[m_addr[11:0]] : 16'h0;
    p_a1 <= p_a0;
    p_b0 <= (b_m_en && !b_m_we) ? mem_b[b_m_addr[11:0]] : 16'h0;
  end
  assign m_rdata   = p_a1;
  assign b_m_rdata = p_b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic       grants [0:9];
  logic       exp_grants [0:9];
  int         n_gnt;
  int         max_burst;
  int         guard;
  logic       finished;
  int         done_cycle;
  logic       prev_en;
  logic       overlap;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    exp_grants = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    nc(); nc();
    mid();
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_owner", 32'(dut.owner), 32'(OWN_IF));
    chk("rst_burst", 32'(dut.burst_cnt), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_strobes", {28'd0, if_gnt, d_gnt, if_done, d_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // IF read alone
    if_req = 1; if_addr = 16'h0010;
    mid(); chk("if_c0_stall", 32'(if_stall), 32'd1); chk("if_c0_gnt", 32'(if_gnt), 32'd0);
    nc(); mid();
    chk("if_c1_gnt", 32'(if_gnt), 32'd1); chk("if_c1_m_en", 32'(m_en), 32'd1);
    chk("if_c1_m_addr", 32'(m_addr), 32'h0010); chk("if_c1_m_we", 32'(m_we), 32'd0);
    nc(); mid();
    chk("if_c2_m_en", 32'(m_en), 32'd0); chk("if_c2_stall", 32'(if_stall), 32'd1);
    nc(); mid();
    chk("if_c3_done", 32'(if_done), 32'd0); chk("if_c3_stall", 32'(if_stall), 32'd1);
    nc(); mid();
    chk("if_c4_done", 32'(if_done), 32'd1); chk("if_c4_rdata", 32'(if_rdata), 32'hA5C3);
    chk("if_c4_stall", 32'(if_stall), 32'd0);
    nc(); if_req = 0;

    // D store alone
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    mid(); chk("st_c0_stall", 32'(d_stall), 32'd1);
    nc(); mid();
    chk("st_c1_m_en", 32'(m_en), 32'd1); chk("st_c1_m_we", 32'(m_we), 32'd1);
    chk("st_c1_gnt", 32'(d_gnt), 32'd1); chk("st_c1_wdata", 32'(m_wdata), 32'h1234);
    nc(); mid();
    chk("st_c2_done", 32'(d_done), 32'd1); chk("st_c2_stall", 32'(d_stall), 32'd0);
    chk("st_c2_rdata", 32'(d_rdata), 32'd0);
    nc(); d_req = 0; d_we = 0;

    // D read back of the stored word
    d_req = 1;
    nc(); nc(); nc(); nc(); mid();
    chk("ld_c4_done", 32'(d_done), 32'd1); chk("ld_c4_rdata", 32'(d_rdata), 32'h1234);
    chk("ld_if_rdata_hold", 32'(if_rdata), 32'hA5C3);
    nc(); d_req = 0;

    // Both held continuously: burst fairness
    if_req = 1; d_req = 1; d_we = 0;
    n_gnt = 0; max_burst = 0; guard = 0; finished = 0;
    while (!finished && guard < 200) begin
      mid();
      if (int'(dut.burst_cnt) > max_burst) max_burst = int'(dut.burst_cnt);
      if (if_gnt && n_gnt < 10) begin grants[n_gnt] = 1'b0; n_gnt++; end
      if (d_gnt && n_gnt < 10) begin grants[n_gnt] = 1'b1; n_gnt++; end
      if (n_gnt >= 10 && if_done) finished = 1;
      nc();
      guard++;
    end
    if_req = 0; d_req = 0;
    chk("burst_finished", 32'(finished), 32'd1);
    chk("burst_n_gnt", 32'(n_gnt), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("grant_%0d_is_d", i), 32'(grants[i]), 32'(exp_grants[i]));
    chk("burst_max", 32'(max_burst), 32'd4);

    // Reset during a read's WAIT
    nc();
    if_req = 1; if_addr = 16'h0010;
    nc(); nc(); mid();
    chk("rw_state_wait", 32'(dut.state), 32'(WAIT));
    reset = 1'b1;
    #1;
    chk("rw_state_idle", 32'(dut.state), 32'(IDLE));
    chk("rw_m_en", 32'(m_en), 32'd0);
    chk("rw_m_addr", 32'(m_addr), 32'd0);
    chk("rw_if_done", 32'(if_done), 32'd0);
    chk("rw_if_rdata", 32'(if_rdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_cycle = -1;
    for (int c = 0; c < 12; c++) begin
      mid();
      if (if_done && done_cycle < 0) done_cycle = c;
      if (if_done) chk("rw_rdata", 32'(if_rdata), 32'hA5C3);
      nc();
      if (done_cycle >= 0) if_req = 0;
    end
    chk("rw_done_cycle", 32'(done_cycle), 32'd4);

    // LATENCY=1 back-to-back loads
    b_d_req = 1; b_d_we = 0; b_d_addr = 16'h0003;
    prev_en = 0; overlap = 0;
    for (int c = 0; c < 9; c++) begin
      mid();
      if (b_m_en && prev_en) overlap = 1;
      prev_en = b_m_en;
      chk($sformatf("l1_done_c%0d", c), 32'(b_d_done), 32'((c == 3) || (c == 7)));
      if (c == 3) chk("l1_rdata_3", 32'(b_d_rdata), 32'h1111);
      if (c == 7) chk("l1_rdata_4", 32'(b_d_rdata), 32'h2222);
      nc();
      if (c == 3) b_d_addr = 16'h0004;
      if (c == 7) b_d_req = 0;
    end
    chk("l1_m_en_no_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
